// File: rtl/simd_mem_pkg.sv
// Shared memory-port types for the SIMD processor data BRAM.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package simd_mem_pkg;

    localparam int ADDR_W = 13;
    localparam int DATA_W = 32;
    localparam int BE_W   = 4;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
        logic [BE_W-1:0]   we;
    } mem_req_t;

    // An access with no byte lanes enabled is a read.
    function automatic logic is_read(input logic [BE_W-1:0] we);
        return (we == '0);
    endfunction

endpackage

// File: rtl/rd_tag_pipe.sv
// Read-return tracker: shifts {valid, requester id} alongside the BRAM access.
// Latency: DEPTH cycles from push to tail.
// Backpressure: none; one push per cycle, tail is a single-cycle pulse.
//
// Ports: clk/rst_n (async active-low clear), push_vld/push_id (new read tag),
//        tail_vld/tail_id (tag whose BRAM data is on doutb this cycle).
module rd_tag_pipe
    import simd_mem_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic push_vld,
    input  logic push_id,
    output logic tail_vld,
    output logic tail_id
);

    logic [DEPTH-1:0] vld_q;
    logic [DEPTH-1:0] id_q;

    // Reset drops every in-flight tag so no stale response appears afterwards.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q <= '0;
            id_q  <= '0;
        end else begin
            vld_q <= {vld_q[DEPTH-2:0], push_vld};
            id_q  <= {id_q[DEPTH-2:0], push_id};
        end
    end

    assign tail_vld = vld_q[DEPTH-1];
    assign tail_id  = id_q[DEPTH-1];

endmodule

// File: rtl/bram_port_arbiter.sv
// Shares BRAM port B between the core load/store path (req0) and the host scanner (req1).
// Latency: accept in T drives the BRAM in T+1; read data returns in T+1+RD_LAT.
// Backpressure: combinational ready; req0 has priority, req1 forced through after STARVE_MAX waits.
//
// Ports: CLK/RSTN; reqN_valid/ready/addr/wdata/we (we==0 is a read);
//        rspN_valid/rdata (rdata mirrors doutb); addrb/dinb/enb/web registered BRAM drive; doutb.
module bram_port_arbiter #(
    parameter int ADDR_W     = simd_mem_pkg::ADDR_W,
    parameter int DATA_W     = simd_mem_pkg::DATA_W,
    parameter int RD_LAT     = 1,
    parameter int STARVE_MAX = 8
) (
    input  logic                          CLK,
    input  logic                          RSTN,
    input  logic                          req0_valid,
    output logic                          req0_ready,
    input  logic [ADDR_W-1:0]             req0_addr,
    input  logic [DATA_W-1:0]             req0_wdata,
    input  logic [simd_mem_pkg::BE_W-1:0] req0_we,
    input  logic                          req1_valid,
    output logic                          req1_ready,
    input  logic [ADDR_W-1:0]             req1_addr,
    input  logic [DATA_W-1:0]             req1_wdata,
    input  logic [simd_mem_pkg::BE_W-1:0] req1_we,
    output logic                          rsp0_valid,
    output logic [DATA_W-1:0]             rsp0_rdata,
    output logic                          rsp1_valid,
    output logic [DATA_W-1:0]             rsp1_rdata,
    output logic [ADDR_W-1:0]             addrb,
    output logic [DATA_W-1:0]             dinb,
    input  logic [DATA_W-1:0]             doutb,
    output logic                          enb,
    output logic [simd_mem_pkg::BE_W-1:0] web
);

    localparam logic [7:0] STARVE_LIM = 8'(STARVE_MAX);

    logic                          gnt0;
    logic                          gnt1;
    logic                          force1;
    logic                          acc;
    logic [7:0]                    wait1;
    logic [ADDR_W-1:0]             win_addr;
    logic [DATA_W-1:0]             win_wdata;
    logic [simd_mem_pkg::BE_W-1:0] win_we;
    logic                          tail_vld;
    logic                          tail_id;

    // req1 wins when req0 is idle, or when it has waited STARVE_MAX cycles in a row.
    assign force1 = req1_valid & (wait1 == STARVE_LIM);
    assign gnt1   = req1_valid & (~req0_valid | force1);
    assign gnt0   = req0_valid & ~gnt1;
    assign acc    = gnt0 | gnt1;

    // Ready is masked during reset so nothing upstream sees a phantom accept.
    assign req0_ready = gnt0 & RSTN;
    assign req1_ready = gnt1 & RSTN;

    always_comb begin
        win_addr  = req0_addr;
        win_wdata = req0_wdata;
        win_we    = req0_we;
        if (gnt1) begin
            win_addr  = req1_addr;
            win_wdata = req1_wdata;
            win_we    = req1_we;
        end
    end

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            enb   <= 1'b0;
            web   <= '0;
            addrb <= '0;
            dinb  <= '0;
            wait1 <= '0;
        end else begin
            enb <= acc;
            web <= acc ? win_we : '0;
            // Address and data hold between accesses; only enb/web qualify them.
            if (acc) begin
                addrb <= win_addr;
                dinb  <= win_wdata;
            end
            // Counts consecutive losing cycles; saturation is never reached in
            // practice because the forced grant fires at STARVE_MAX.
            if (!req1_valid || gnt1) begin
                wait1 <= '0;
            end else if (wait1 != 8'hFF) begin
                wait1 <= wait1 + 8'd1;
            end
        end
    end

    // One stage covers the register-to-BRAM cycle, RD_LAT more cover the BRAM itself.
    rd_tag_pipe #(
        .DEPTH (1 + RD_LAT)
    ) u_rd_tag_pipe (
        .clk      (CLK),
        .rst_n    (RSTN),
        .push_vld (acc & simd_mem_pkg::is_read(win_we)),
        .push_id  (gnt1),
        .tail_vld (tail_vld),
        .tail_id  (tail_id)
    );

    assign rsp0_valid = tail_vld & ~tail_id;
    assign rsp1_valid = tail_vld & tail_id;
    assign rsp0_rdata = doutb;
    assign rsp1_rdata = doutb;

endmodule

// File: tb/tb_bram_port_arbiter.sv
// Self-checking bench for bram_port_arbiter (RD_LAT=1 main instance, RD_LAT=2 side instance).
// Latency: n/a.
// Backpressure: n/a.
module tb_bram_port_arbiter;

    logic        CLK;
    logic        RSTN;
    logic        req0_valid, req1_valid, req0_ready, req1_ready;
    logic [12:0] req0_addr, req1_addr, addrb;
    logic [31:0] req0_wdata, req1_wdata, dinb, doutb, rsp0_rdata, rsp1_rdata;
    logic [3:0]  req0_we, req1_we, web;
    logic        rsp0_valid, rsp1_valid, enb;

    logic        b_req0_valid, b_req0_ready, b_req1_ready;
    logic [12:0] b_req0_addr, b_addrb;
    logic [31:0] b_dinb, b_doutb, b_rsp0_rdata, b_rsp1_rdata;
    logic [3:0]  b_web;
    logic        b_rsp0_valid, b_rsp1_valid, b_enb;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    typedef struct {
        logic        id;
        logic [31:0] data;
        int          due;
    } exp_t;
    exp_t sb[$];

    typedef struct {
        logic        v0;
        logic [3:0]  we0;
        logic [12:0] a0;
        logic        v1;
        logic [3:0]  we1;
        logic [12:0] a1;
        logic        e0;
        logic        e1;
    } vec_t;
    vec_t tbl[10];

    logic [31:0] mem1   [8192];
    logic [31:0] mem2   [8192];
    logic [31:0] shadow [8192];
    logic [31:0] q1, b_q1, b_q2;

    bram_port_arbiter #(.RD_LAT(1), .STARVE_MAX(8)) u_dut (
        .CLK(CLK), .RSTN(RSTN),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_addr(req0_addr),
        .req0_wdata(req0_wdata), .req0_we(req0_we),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_addr(req1_addr),
        .req1_wdata(req1_wdata), .req1_we(req1_we),
        .rsp0_valid(rsp0_valid), .rsp0_rdata(rsp0_rdata),
        .rsp1_valid(rsp1_valid), .rsp1_rdata(rsp1_rdata),
        .addrb(addrb), .dinb(dinb), .doutb(doutb), .enb(enb), .web(web)
    );

    bram_port_arbiter #(.RD_LAT(2), .STARVE_MAX(8)) u_dut2 (
        .CLK(CLK), .RSTN(RSTN),
        .req0_valid(b_req0_valid), .req0_ready(b_req0_ready), .req0_addr(b_req0_addr),
        .req0_wdata(32'h0), .req0_we(4'h0),
        .req1_valid(1'b0), .req1_ready(b_req1_ready), .req1_addr(13'h0),
        .req1_wdata(32'h0), .req1_we(4'h0),
        .rsp0_valid(b_rsp0_valid), .rsp0_rdata(b_rsp0_rdata),
        .rsp1_valid(b_rsp1_valid), .rsp1_rdata(b_rsp1_rdata),
        .addrb(b_addrb), .dinb(b_dinb), .doutb(b_doutb), .enb(b_enb), .web(b_web)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc <= cyc + 1;

    // Read-first BRAM models with byte-lane writes.
    always @(posedge CLK) begin
        if (enb) begin
            q1 <= mem1[addrb];
            for (int b = 0; b < 4; b++)
                if (web[b]) mem1[addrb][8*b +: 8] <= dinb[8*b +: 8];
        end
    end
    assign doutb = q1;

    always @(posedge CLK) begin
        if (b_enb) begin
            b_q1 <= mem2[b_addrb];
            for (int b = 0; b < 4; b++)
                if (b_web[b]) mem2[b_addrb][8*b +: 8] <= b_dinb[8*b +: 8];
        end
        b_q2 <= b_q1;
    end
    assign b_doutb = b_q2;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
        n_cmp++;
        if (act !== exp_v) begin
            n_bad++;
            $display("FAIL %s: actual %h required %h (cycle %0d)", nm, act, exp_v, cyc);
        end
    endtask

    // Response monitor: every rsp pulse must match the oldest expected read, on its due cycle.
    always @(negedge CLK) begin
        if (RSTN) begin
            if (rsp0_valid || rsp1_valid) begin
                chk("rsp_onehot", {31'b0, rsp0_valid & rsp1_valid}, 32'h0);
                if (sb.size() == 0) begin
                    chk("rsp_unexpected", {30'b0, rsp1_valid, rsp0_valid}, 32'h0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("rsp_id", {31'b0, rsp1_valid}, {31'b0, e.id});
                    chk("rsp_data", rsp1_valid ? rsp1_rdata : rsp0_rdata, e.data);
                    chk("rsp_cycle", cyc, e.due);
                end
            end else if (sb.size() > 0 && sb[0].due <= cyc) begin
                n_cmp++;
                n_bad++;
                $display("FAIL rsp_missing: no response, required id %0d data %h at cycle %0d",
                         sb[0].id, sb[0].data, sb[0].due);
                void'(sb.pop_front());
            end
        end
    end

    task automatic note_accept(input logic id, input logic [3:0] we, input logic [12:0] a,
                               input logic [31:0] d);
        if (we == 4'h0) begin
            sb.push_back('{id: id, data: shadow[a], due: cyc + 2});
        end else begin
            for (int b = 0; b < 4; b++)
                if (we[b]) shadow[a][8*b +: 8] = d[8*b +: 8];
        end
    endtask

    // Drive one cycle of requests, check grants, record expected responses.
    task automatic step(input logic v0, input logic [3:0] we0, input logic [12:0] a0,
                        input logic [31:0] d0, input logic v1, input logic [3:0] we1,
                        input logic [12:0] a1, input logic [31:0] d1,
                        input logic e0, input logic e1, input string tag);
        req0_valid = v0; req0_we = we0; req0_addr = a0; req0_wdata = d0;
        req1_valid = v1; req1_we = we1; req1_addr = a1; req1_wdata = d1;
        @(negedge CLK);
        chk({tag, "_rdy0"}, {31'b0, req0_ready}, {31'b0, e0});
        chk({tag, "_rdy1"}, {31'b0, req1_ready}, {31'b0, e1});
        if (e0) note_accept(1'b0, we0, a0, d0);
        if (e1) note_accept(1'b1, we1, a1, d1);
        @(posedge CLK);
        #1;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++)
            step(0, 4'h0, 13'h0, 32'h0, 0, 4'h0, 13'h0, 32'h0, 0, 0, "idle");
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [12:0] a1c;
        for (int i = 0; i < 8192; i++) begin
            mem1[i]   = 32'h5A00_0000 | i;
            mem2[i]   = 32'h5A00_0000 | i;
            shadow[i] = 32'h5A00_0000 | i;
        end
        mem1[16]     = 32'hDEADBEEF; mem2[16] = 32'hDEADBEEF; shadow[16] = 32'hDEADBEEF;
        mem1[13'h1FFF] = 32'h11223344; shadow[13'h1FFF] = 32'h11223344;

        tbl[0] = '{0, 4'h0, 13'h000, 0, 4'h0, 13'h000, 0, 0};
        tbl[1] = '{1, 4'h0, 13'h020, 0, 4'h0, 13'h000, 1, 0};
        tbl[2] = '{0, 4'h0, 13'h000, 1, 4'h0, 13'h021, 0, 1};
        tbl[3] = '{1, 4'h0, 13'h022, 1, 4'h0, 13'h023, 1, 0};
        tbl[4] = '{1, 4'h0, 13'h024, 1, 4'h0, 13'h023, 1, 0};
        tbl[5] = '{0, 4'h0, 13'h000, 1, 4'h0, 13'h023, 0, 1};
        tbl[6] = '{1, 4'hF, 13'h030, 1, 4'h0, 13'h030, 1, 0};
        tbl[7] = '{1, 4'h0, 13'h030, 0, 4'h0, 13'h000, 1, 0};
        tbl[8] = '{0, 4'h0, 13'h000, 1, 4'h8, 13'h031, 0, 1};
        tbl[9] = '{1, 4'h0, 13'h031, 0, 4'h0, 13'h000, 1, 0};

        // Reset state, with requests present to show ready is masked.
        RSTN = 1'b0;
        req0_valid = 1; req0_we = 4'hF; req0_addr = 13'h5; req0_wdata = 32'h1;
        req1_valid = 1; req1_we = 4'h0; req1_addr = 13'h6; req1_wdata = 32'h2;
        b_req0_valid = 0; b_req0_addr = 13'h0;
        #2;
        chk("rst_enb", {31'b0, enb}, 32'h0);
        chk("rst_web", {28'b0, web}, 32'h0);
        chk("rst_addrb", {19'b0, addrb}, 32'h0);
        chk("rst_dinb", dinb, 32'h0);
        chk("rst_rsp", {30'b0, rsp1_valid, rsp0_valid}, 32'h0);
        chk("rst_ready", {30'b0, req1_ready, req0_ready}, 32'h0);
        @(posedge CLK); @(posedge CLK); #1;
        RSTN = 1'b1;
        idle(1);

        // Single read from requester 0.
        step(1, 4'h0, 13'h0010, 32'h0, 0, 4'h0, 13'h0, 32'h0, 1, 0, "rd0");
        chk("rd0_enb", {31'b0, enb}, 32'h1);
        chk("rd0_addrb", {19'b0, addrb}, 32'h0010);
        chk("rd0_web", {28'b0, web}, 32'h0);
        idle(1);
        chk("rd0_rsp_valid", {30'b0, rsp1_valid, rsp0_valid}, 32'h1);
        chk("rd0_rsp_data", rsp0_rdata, 32'hDEADBEEF);
        chk("rd0_enb_off", {31'b0, enb}, 32'h0);
        idle(1);

        // Partial write then read-back from requester 1, on consecutive cycles.
        step(0, 4'h0, 13'h0, 32'h0, 1, 4'b0011, 13'h1FFF, 32'hCAFEF00D, 0, 1, "wr1");
        chk("wr1_enb", {31'b0, enb}, 32'h1);
        chk("wr1_web", {28'b0, web}, 32'h3);
        chk("wr1_addrb", {19'b0, addrb}, 32'h1FFF);
        chk("wr1_dinb", dinb, 32'hCAFEF00D);
        step(0, 4'h0, 13'h0, 32'h0, 1, 4'h0, 13'h1FFF, 32'h0, 0, 1, "rd1");
        chk("rd1_web", {28'b0, web}, 32'h0);
        chk("rd1_enb", {31'b0, enb}, 32'h1);
        idle(1);
        chk("rd1_rsp_valid", {30'b0, rsp1_valid, rsp0_valid}, 32'h2);
        chk("rd1_rsp_data", rsp1_rdata, 32'h1122F00D);
        idle(1);

        // Grant table.
        for (int i = 0; i < 10; i++)
            step(tbl[i].v0, tbl[i].we0, tbl[i].a0, 32'hA5A5_0000 | i,
                 tbl[i].v1, tbl[i].we1, tbl[i].a1, 32'h3C00_0000 | i,
                 tbl[i].e0, tbl[i].e1, $sformatf("tbl%0d", i));
        idle(1);

        // Continuous contention: 8 grants to req0, then one forced grant to req1.
        a1c = 13'h200;
        for (int i = 0; i < 27; i++) begin
            step(1, 4'h0, 13'h100 + 13'(i), 32'h0, 1, 4'h0, a1c, 32'h0,
                 (i % 9) != 8, (i % 9) == 8, $sformatf("cont%0d", i));
            if ((i % 9) == 8) a1c = a1c + 13'h1;
        end
        idle(1);

        // Interleaved reads return in issue order on consecutive cycles.
        step(1, 4'h0, 13'h040, 32'h0, 0, 4'h0, 13'h0, 32'h0, 1, 0, "ilvA");
        step(0, 4'h0, 13'h0, 32'h0, 1, 4'h0, 13'h041, 32'h0, 0, 1, "ilvB");
        step(1, 4'h0, 13'h042, 32'h0, 0, 4'h0, 13'h0, 32'h0, 1, 0, "ilvC");
        idle(4);

        // Reset while two reads are in flight.
        step(1, 4'h0, 13'h050, 32'h0, 0, 4'h0, 13'h0, 32'h0, 1, 0, "rstA");
        step(0, 4'h0, 13'h0, 32'h0, 1, 4'h0, 13'h051, 32'h0, 0, 1, "rstB");
        RSTN = 1'b0;
        sb.delete();
        req0_valid = 1; req1_valid = 1; req0_we = 4'hF;
        #1;
        chk("mrst_enb", {31'b0, enb}, 32'h0);
        chk("mrst_web", {28'b0, web}, 32'h0);
        chk("mrst_addrb", {19'b0, addrb}, 32'h0);
        chk("mrst_rsp", {30'b0, rsp1_valid, rsp0_valid}, 32'h0);
        chk("mrst_ready", {30'b0, req1_ready, req0_ready}, 32'h0);
        @(negedge CLK);
        chk("mrst_enb_hold", {31'b0, enb}, 32'h0);
        chk("mrst_rsp_hold", {30'b0, rsp1_valid, rsp0_valid}, 32'h0);
        @(posedge CLK); #1;
        req0_valid = 0; req1_valid = 0; req0_we = 4'h0;
        RSTN = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge CLK);
            chk($sformatf("mrst_norsp%0d", k), {30'b0, rsp1_valid, rsp0_valid}, 32'h0);
        end
        @(posedge CLK); #1;

        // RD_LAT=2 instance: single read, response one cycle later than the main instance.
        b_req0_valid = 1; b_req0_addr = 13'h0010;
        @(negedge CLK);
        chk("lat2_rdy", {31'b0, b_req0_ready}, 32'h1);
        @(posedge CLK); #1;
        b_req0_valid = 0;
        chk("lat2_enb", {31'b0, b_enb}, 32'h1);
        chk("lat2_addrb", {19'b0, b_addrb}, 32'h0010);
        for (int k = 1; k <= 4; k++) begin
            chk($sformatf("lat2_rsp0_t%0d", k), {31'b0, b_rsp0_valid}, {31'b0, k == 3});
            chk($sformatf("lat2_rsp1_t%0d", k), {31'b0, b_rsp1_valid}, 32'h0);
            if (k == 3) chk("lat2_data", b_rsp0_rdata, 32'hDEADBEEF);
            @(posedge CLK); #1;
        end

        // Drain any outstanding expected responses, bounded.
        for (int k = 0; k < 8 && sb.size() > 0; k++) @(posedge CLK);
        #1;
        if (sb.size() > 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain: %0d expected responses never arrived, required 0", sb.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
